// File: rtl/snoop_initiator.sv
// Bus-side snoop initiator: snoops the cache on a read request, forwards any
// modified-line writeback beats to memory, then fetches the line and signals done.
module snoop_initiator #(
    parameter int AW         = 32,
    parameter int HIT_WIN    = 4,
    parameter int WB_BEATS   = 4,
    parameter int WB_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic [AW-1:0] req_addr,
    output logic          req_ready,
    output logic          snoop,
    output logic [AW-1:0] snoop_addr,
    input  logic          hit_modified,
    input  logic          writeback,
    output logic          fetch,
    output logic          rd,
    output logic          wr,
    input  logic          mem_ready,
    output logic          done,
    output logic          wb_err,
    output logic [2:0]    dbg_state
);

    // Handshake: a request is taken on a clock edge where req_valid && req_ready;
    // req_ready is only high in IDLE, and the requester holds req_valid until then.

    localparam int WIN_W  = $clog2(HIT_WIN) + 1;
    localparam int BEAT_W = $clog2(WB_BEATS) + 1;
    localparam int TMO_W  = $clog2(WB_TIMEOUT) + 1;

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(HIT_WIN - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(WB_BEATS - 1);
    localparam logic [BEAT_W-1:0] BEAT_END  = BEAT_W'(WB_BEATS);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(WB_TIMEOUT - 1);
    localparam logic [TMO_W-1:0]  TMO_END   = TMO_W'(WB_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SNOOP    = 3'd1,
        WAIT_HIT = 3'd2,
        WB       = 3'd3,
        FETCH    = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [WIN_W-1:0]    r_win_cnt;
    logic [WIN_W-1:0]    w_win_nxt;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic [BEAT_W-1:0]   w_beat_nxt;
    logic [TMO_W-1:0]    r_tmo_cnt;
    logic [TMO_W-1:0]    w_tmo_nxt;
    logic                w_accept;
    logic                w_tmo_err;
    logic                w_spurious;

    logic                r_req_ready;
    logic                r_snoop;
    logic [AW-1:0]       r_snoop_addr;
    logic                r_fetch;
    logic                r_wr;
    logic                r_done;
    logic                r_wb_err;

    always_comb begin
        w_next     = r_state;
        w_win_nxt  = r_win_cnt;
        w_beat_nxt = r_beat_cnt;
        w_tmo_nxt  = r_tmo_cnt;
        w_accept   = 1'b0;
        w_tmo_err  = 1'b0;
        w_spurious = writeback && (r_state != WB);
        case (r_state)
            IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_accept = 1'b1;
                    w_next   = SNOOP;
                end
            end
            SNOOP: begin
                w_next    = WAIT_HIT;
                w_win_nxt = '0;
            end
            WAIT_HIT: begin
                // A hit in the final window cycle still wins over the miss path.
                if (hit_modified) begin
                    w_next     = WB;
                    w_beat_nxt = '0;
                    w_tmo_nxt  = '0;
                end else if (r_win_cnt == WIN_LAST) begin
                    w_next = FETCH;
                end else begin
                    w_win_nxt = r_win_cnt + 1'b1;
                end
            end
            WB: begin
                if (writeback && (r_beat_cnt == BEAT_LAST)) begin
                    w_next     = FETCH;
                    w_beat_nxt = BEAT_END;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_next    = IDLE;
                    w_tmo_nxt = TMO_END;
                    w_tmo_err = 1'b1;
                    if (writeback) begin
                        w_beat_nxt = r_beat_cnt + 1'b1;
                    end
                end else begin
                    w_tmo_nxt = r_tmo_cnt + 1'b1;
                    if (writeback) begin
                        w_beat_nxt = r_beat_cnt + 1'b1;
                    end
                end
            end
            FETCH: begin
                if (mem_ready) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_win_cnt    <= '0;
            r_beat_cnt   <= '0;
            r_tmo_cnt    <= '0;
            r_req_ready  <= 1'b0;
            r_snoop      <= 1'b0;
            r_snoop_addr <= '0;
            r_fetch      <= 1'b0;
            r_wr         <= 1'b0;
            r_done       <= 1'b0;
            r_wb_err     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_win_cnt   <= w_win_nxt;
            r_beat_cnt  <= w_beat_nxt;
            r_tmo_cnt   <= w_tmo_nxt;
            r_req_ready <= (w_next == IDLE);
            r_snoop     <= (w_next == SNOOP);
            r_fetch     <= (w_next == FETCH);
            r_done      <= (w_next == DONE);
            r_wr        <= (r_state == WB) && writeback;
            r_wb_err    <= r_wb_err | w_tmo_err | w_spurious;
            if (w_accept) begin
                r_snoop_addr <= req_addr;
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign snoop      = r_snoop;
    assign snoop_addr = r_snoop_addr;
    assign fetch      = r_fetch;
    assign rd         = r_fetch;
    assign wr         = r_wr;
    assign done       = r_done;
    assign wb_err     = r_wb_err;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_snoop_initiator.sv
// Bench for snoop_initiator: directed transaction table, hand-written reset and
// error sequences, then randomized transactions against a cycle-schedule model.
module tb_snoop_initiator;

    localparam int AW         = 32;
    localparam int HIT_WIN    = 4;
    localparam int WB_BEATS   = 4;
    localparam int WB_TIMEOUT = 16;
    localparam int MAXC       = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic          hit_modified = 1'b0;
    logic          writeback = 1'b0;
    logic          mem_ready = 1'b0;
    logic          req_ready, snoop, fetch, rd, wr, done, wb_err;
    logic [AW-1:0] snoop_addr;
    logic [2:0]    dbg_state;

    snoop_initiator #(
        .AW(AW), .HIT_WIN(HIT_WIN), .WB_BEATS(WB_BEATS), .WB_TIMEOUT(WB_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .snoop(snoop), .snoop_addr(snoop_addr),
        .hit_modified(hit_modified), .writeback(writeback), .fetch(fetch),
        .rd(rd), .wr(wr), .mem_ready(mem_ready), .done(done), .wb_err(wb_err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Input schedule and expected outputs, one entry per cycle of a transaction.
    logic          s_req[MAXC];
    logic          s_hit[MAXC];
    logic          s_wb[MAXC];
    logic          s_mr[MAXC];
    logic [AW-1:0] s_addr[MAXC];
    logic [6:0]    ex_vec[MAXC];
    logic [AW-1:0] ex_addr[MAXC];
    int            sched_len;
    logic          err_model = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    int            a_fetch, a_done, a_wr, a_end;
    logic          a_err;

    typedef struct {
        logic [AW-1:0] addr;
        int            hit_at;
        int            n_beats;
        int            mem_delay;
        int            exp_fetch;
        int            exp_done;
        int            exp_wr;
        int            exp_end;
        logic          exp_err;
    } vec_t;

    // Output vector order: {req_ready, snoop, fetch, rd, wr, done, wb_err}.
    function automatic logic [6:0] pack(input logic rdy, sn, fe, r, w, dn, er);
        return {rdy, sn, fe, r, w, dn, er};
    endfunction

    function automatic logic [6:0] cur_vec();
        return {req_ready, snoop, fetch, rd, wr, done, wb_err};
    endfunction

    task automatic check_vec(input string name, input logic [6:0] exp_v, input logic [AW-1:0] exp_a);
        n_cmp++;
        if (cur_vec() !== exp_v || snoop_addr !== exp_a) begin
            n_bad++;
            $display("FAIL %s: got rdy/sn/fe/rd/wr/dn/err=%b addr=%h, expected %b addr=%h",
                     name, cur_vec(), snoop_addr, exp_v, exp_a);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp_i);
        n_cmp++;
        if (act != exp_i) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_i);
        end
    endtask

    // Lay out one transaction as a cycle schedule; cycle 0 is IDLE with req_valid.
    task automatic build(input logic [AW-1:0] addr, input int hit_at, input int n_beats,
                         input int gap_max, input int d, input bit noise, input bit spur);
        int   w, f, endc, off, last_c, wait_last;
        logic has_fetch, tmo;
        logic beat_at[MAXC];
        logic fwin;
        for (int i = 0; i < MAXC; i++) begin
            s_req[i] = 1'b0; s_hit[i] = 1'b0; s_wb[i] = 1'b0; s_mr[i] = 1'b0;
            s_addr[i] = '0; beat_at[i] = 1'b0;
            ex_vec[i] = '0; ex_addr[i] = '0;
        end
        s_req[0]  = 1'b1;
        s_addr[0] = addr;
        s_wb[0]   = spur;
        has_fetch = 1'b1;
        tmo       = 1'b0;
        f         = 2 + HIT_WIN;
        endc      = 0;
        last_c    = 0;
        if (hit_at > 0) begin
            w = 2 + hit_at;
            s_hit[1 + hit_at] = 1'b1;
            off = $urandom_range(0, gap_max);
            for (int b = 0; b < n_beats; b++) begin
                beat_at[w + off] = 1'b1;
                s_wb[w + off]    = 1'b1;
                last_c = w + off;
                off = off + 1 + $urandom_range(0, gap_max);
            end
            if (n_beats == WB_BEATS) begin
                f = last_c + 1;
            end else begin
                has_fetch = 1'b0;
                tmo       = 1'b1;
                endc      = w + WB_TIMEOUT;
            end
        end
        if (has_fetch) begin
            s_mr[f + d] = 1'b1;
            endc = f + d + 2;
        end
        wait_last = 1 + ((hit_at > 0) ? hit_at : HIT_WIN);
        if (noise) begin
            for (int c = 1; c < endc; c++) begin
                s_req[c]  = 1'($urandom_range(0, 1));
                s_addr[c] = $urandom;
            end
            for (int c = 0; c <= endc; c++) begin
                if (c < 2 || c > wait_last) s_hit[c] = 1'($urandom_range(0, 1));
            end
        end
        for (int c = 0; c <= endc; c++) begin
            fwin = has_fetch && (c >= f) && (c <= f + d);
            ex_vec[c] = pack(c == 0 || c == endc, c == 1, fwin, fwin,
                             (c > 0) ? beat_at[c - 1] : 1'b0,
                             has_fetch && (c == f + d + 1),
                             err_model || (spur && c >= 1) || (tmo && c >= endc));
            ex_addr[c] = (c == 0) ? prev_addr : addr;
        end
        sched_len = endc + 1;
    endtask

    task automatic run_txn(input string tag, input int limit);
        int n;
        n = (limit < sched_len) ? limit : sched_len;
        a_fetch = -1; a_done = -1; a_wr = 0; a_end = -1; a_err = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            n_cmp++;
            if (cur_vec() !== ex_vec[c] || snoop_addr !== ex_addr[c]) begin
                n_bad++;
                $display("FAIL %s cyc %0d: got rdy/sn/fe/rd/wr/dn/err=%b addr=%h, expected %b addr=%h",
                         tag, c, cur_vec(), snoop_addr, ex_vec[c], ex_addr[c]);
            end
            if (fetch && a_fetch < 0) a_fetch = c;
            if (done && a_done < 0) a_done = c;
            if (wr) a_wr++;
            if (c > 0 && req_ready && a_end < 0) a_end = c;
            a_err = wb_err;
            req_valid    = s_req[c];
            req_addr     = s_addr[c];
            hit_modified = s_hit[c];
            writeback    = s_wb[c];
            mem_ready    = s_mr[c];
        end
        err_model = ex_vec[sched_len - 1][0];
        prev_addr = s_addr[0];
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid = 1'b0; hit_modified = 1'b0; writeback = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_vec("reset_state", pack(0, 0, 0, 0, 0, 0, 0), '0);
        reset = 1'b0;
        @(negedge clk);
        check_vec("reset_release_ready", pack(1, 0, 0, 0, 0, 0, 0), '0);
        err_model = 1'b0;
        prev_addr = '0;
    endtask

    vec_t tbl[5];

    initial begin
        int hit_at, nb;
        bit spur;
        tbl[0] = '{32'h0000_1000, 0, 0, 1, 6, 8, 0, 9, 1'b0};
        tbl[1] = '{32'h0000_2040, 2, 4, 0, 8, 9, 4, 10, 1'b0};
        tbl[2] = '{32'h0000_3080, 4, 4, 2, 10, 13, 4, 14, 1'b0};
        tbl[3] = '{32'hDEAD_BEC0, 1, 4, 0, 7, 8, 4, 9, 1'b0};
        tbl[4] = '{32'h0000_5000, 2, 2, 0, -1, -1, 2, 20, 1'b1};

        do_reset();

        for (int i = 0; i < 5; i++) begin
            build(tbl[i].addr, tbl[i].hit_at, tbl[i].n_beats, 0, tbl[i].mem_delay, 1'b0, 1'b0);
            run_txn($sformatf("tbl%0d", i), MAXC);
            check_int($sformatf("tbl%0d_fetch_cycle", i), a_fetch, tbl[i].exp_fetch);
            check_int($sformatf("tbl%0d_done_cycle", i), a_done, tbl[i].exp_done);
            check_int($sformatf("tbl%0d_wr_count", i), a_wr, tbl[i].exp_wr);
            check_int($sformatf("tbl%0d_ready_cycle", i), a_end, tbl[i].exp_end);
            check_int($sformatf("tbl%0d_wb_err", i), int'(a_err), int'(tbl[i].exp_err));
        end

        // Spurious writeback in IDLE: error flag, no write, next request still completes.
        do_reset();
        writeback = 1'b1;
        @(negedge clk);
        writeback = 1'b0;
        check_vec("spurious_wb", pack(1, 0, 0, 0, 0, 0, 1), '0);
        @(negedge clk);
        check_vec("spurious_wb_no_wr", pack(1, 0, 0, 0, 0, 0, 1), '0);
        err_model = 1'b1;
        build(32'h0000_6000, 2, 4, 0, 1, 1'b0, 1'b0);
        run_txn("after_spurious", MAXC);
        check_int("after_spurious_done_cycle", a_done, 10);

        // Reset after two writeback beats: abort with no done/fetch/wr afterwards.
        build(32'h0000_7000, 1, 4, 0, 0, 1'b0, 1'b0);
        run_txn("midwb", 5);
        @(negedge clk);
        check_vec("midwb_second_wr", ex_vec[5], ex_addr[5]);
        reset = 1'b1;
        req_valid = 1'b0; hit_modified = 1'b0; writeback = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        check_vec("midwb_reset_outputs", pack(0, 0, 0, 0, 0, 0, 0), '0);
        reset = 1'b0;
        @(negedge clk);
        check_vec("midwb_ready_after_reset", pack(1, 0, 0, 0, 0, 0, 0), '0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_vec($sformatf("midwb_quiet%0d", k), pack(1, 0, 0, 0, 0, 0, 0), '0);
        end
        err_model = 1'b0;
        prev_addr = '0;

        // Randomized transactions with ignored-input noise.
        for (int t = 0; t < 60; t++) begin
            if (err_model) do_reset();
            hit_at = $urandom_range(0, HIT_WIN);
            nb = 0;
            if (hit_at > 0) begin
                nb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, WB_BEATS - 1) : WB_BEATS;
            end
            spur = ($urandom_range(0, 7) == 0);
            build($urandom, hit_at, nb, 2, $urandom_range(0, 3), 1'b1, spur);
            run_txn($sformatf("rand%0d", t), MAXC);
        end

        @(negedge clk);
        req_valid = 1'b0; hit_modified = 1'b0; writeback = 1'b0; mem_ready = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
